// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine feeding the HI/LO register: one op in flight,
// shift-add multiply or restoring divide, result delivered as a one-cycle write strobe.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Start,
  input  logic [2:0]           i_Op,
  input  logic [WIDTH-1:0]     i_OperandA,
  input  logic [WIDTH-1:0]     i_OperandB,
  input  logic [2*WIDTH-1:0]   i_HiLoIn,
  output logic                 o_Busy,
  output logic                 o_HiLoWriteEnable,
  output logic [2*WIDTH-1:0]   o_HiLoWriteData,
  output logic                 o_DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WRITE} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5
  } op_t;

  state_t               r_state;
  state_t               w_nextState;
  op_t                  r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_bIn;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_hiLoIn;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_hiLoWriteData;
  logic                 r_divByZero;

  logic                 w_accept;
  logic                 w_isDiv;
  logic                 w_signedOp;
  logic                 w_signA;
  logic                 w_signB;
  logic                 w_divZero;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [WIDTH:0]       w_addSum;
  logic [WIDTH:0]       w_remShift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_signedProd;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_result;

  assign w_accept   = (r_state == S_IDLE) && i_Start && (i_Op <= 3'd5);
  assign w_isDiv    = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_signedOp = !((r_op == OP_MULTU) || (r_op == OP_DIVU));
  assign w_signA    = w_signedOp & r_a[WIDTH-1];
  assign w_signB    = w_signedOp & r_bIn[WIDTH-1];
  assign w_divZero  = w_isDiv && (r_bIn == '0);
  assign w_magA     = w_signA ? -r_a : r_a;
  assign w_magB     = w_signB ? -r_bIn : r_bIn;

  // One iteration of each algorithm; r_b is the multiplicand or the divisor.
  assign w_addSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_remShift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_b};

  assign w_prod       = {r_hi, r_lo};
  assign w_signedProd = (w_signA ^ w_signB) ? -w_prod : w_prod;
  assign w_quot       = (w_signA ^ w_signB) ? -r_lo : r_lo;
  assign w_rem        = w_signA ? -r_hi : r_hi;

  always_comb begin
    w_result = w_signedProd;
    case (r_op)
      OP_MADD: w_result = r_hiLoIn + w_signedProd;
      OP_MSUB: w_result = r_hiLoIn - w_signedProd;
      OP_DIV, OP_DIVU: begin
        if (w_divZero) w_result = {r_a, {WIDTH{1'b1}}};
        else           w_result = {w_rem, w_quot};
      end
      default: w_result = w_signedProd;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_CALC;
      S_CALC:  if (r_count == CW'(WIDTH)) w_nextState = S_FIX;
      S_FIX:   w_nextState = S_WRITE;
      S_WRITE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  // The first CALC cycle loads the magnitudes; the following WIDTH cycles iterate.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_op            <= OP_MULT;
      r_a             <= '0;
      r_bIn           <= '0;
      r_b             <= '0;
      r_hi            <= '0;
      r_lo            <= '0;
      r_hiLoIn        <= '0;
      r_count         <= '0;
      r_hiLoWriteData <= '0;
      r_divByZero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= op_t'(i_Op);
            r_a         <= i_OperandA;
            r_bIn       <= i_OperandB;
            r_hiLoIn    <= i_HiLoIn;
            r_count     <= '0;
            r_divByZero <= 1'b0;
          end
        end
        S_CALC: begin
          r_count <= r_count + CW'(1);
          if (r_count == '0) begin
            r_hi <= '0;
            r_lo <= w_isDiv ? w_magA : w_magB;
            r_b  <= w_isDiv ? w_magB : w_magA;
          end else if (w_isDiv) begin
            if (!w_diff[WIDTH]) begin
              r_hi <= w_diff[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= w_remShift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_addSum[WIDTH:1];
            r_lo <= {w_addSum[0], r_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hiLoWriteData <= w_result;
          r_divByZero     <= w_divZero;
        end
        default: ;
      endcase
    end
  end

  assign o_Busy            = (r_state != S_IDLE);
  assign o_HiLoWriteEnable = (r_state == S_WRITE);
  assign o_HiLoWriteData   = r_hiLoWriteData;
  assign o_DivByZero       = r_divByZero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  typedef enum logic [2:0] {
    OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
    OP_MADD = 3'd4, OP_MSUB = 3'd5, OP_RES6 = 3'd6, OP_RES7 = 3'd7
  } op_e;

  typedef struct {
    logic [63:0] data;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [63:0]   hilo;
  logic          busy;
  logic          writeEnable;
  logic [63:0]   writeData;
  logic          divByZero;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Start(start),
    .i_Op(op),
    .i_OperandA(a),
    .i_OperandB(b),
    .i_HiLoIn(hilo),
    .o_Busy(busy),
    .o_HiLoWriteEnable(writeEnable),
    .o_HiLoWriteData(writeData),
    .o_DivByZero(divByZero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: whole-number arithmetic on 64-bit integers.
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] h);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return ux * uy;
      OP_MADD:  return h + 64'(sx * sy);
      OP_MSUB:  return h - 64'(sx * sy);
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (writeEnable === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedWrite", 64'(writeData), 64'hx);
      end else begin
        e = sb.pop_front();
        checkOutput("writeData", writeData, e.data);
        checkOutput("divByZero", 64'(divByZero), 64'(e.dbz));
        checkOutput("writeCycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("idleTimeout", 64'(busy), 64'd0);
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [63:0] h, input logic [63:0] expData,
                               input logic expDbz, input bit expectWrite);
    exp_t e;
    waitIdle();
    op = o; a = x; b = y; hilo = h; start = 1'b1;
    if (expectWrite) begin
      e.data = expData;
      e.dbz  = expDbz;
      e.cyc  = cyc + 1 + W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyAfterStart", 64'(busy), 64'd1);
    checkOutput("dbzClearedByStart", 64'(divByZero), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rh;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; hilo = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetWriteEnable", 64'(writeEnable), 64'd0);
    checkOutput("resetWriteData", writeData, 64'd0);
    checkOutput("resetDivByZero", 64'(divByZero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1);
    applyStimulus(OP_MADD, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0005, 1'b0, 1'b1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
    applyStimulus(OP_DIVU, 32'd7, 32'd2, 64'd0, 64'h0000_0001_0000_0003, 1'b0, 1'b1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 1'b1);

    applyStimulus(OP_DIVU, 32'h1234_5678, 32'd0, 64'd0, 64'h1234_5678_FFFF_FFFF, 1'b1, 1'b1);
    waitIdle();
    @(negedge clk);
    checkOutput("dbzSticky", 64'(divByZero), 64'd1);
    checkOutput("dataHeld", writeData, 64'h1234_5678_FFFF_FFFF);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0, 64'd0, 64'hFFFF_FFF9_FFFF_FFFF, 1'b1, 1'b1);

    // Starts presented mid-operation must be ignored.
    applyStimulus(OP_MULT, 32'h0001_2345, 32'hFFFF_FF00, 64'd0,
                  64'hFFFF_FFFF_FEDC_BB00, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    op = OP_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(OP_MULTU, 32'd6, 32'd9, 64'd0, 64'd54, 1'b0, 1'b1);

    // Reserved opcodes do not launch anything.
    waitIdle();
    op = OP_RES6; start = 1'b1;
    @(negedge clk);
    checkOutput("reservedOp6", 64'(busy), 64'd0);
    op = OP_RES7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("reservedOp7", 64'(busy), 64'd0);

    // Reset mid-divide aborts without a write.
    applyStimulus(OP_DIV, 32'hFFFF_0000, 32'd3, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortWriteEnable", 64'(writeEnable), 64'd0);
    checkOutput("abortWriteData", writeData, 64'd0);
    op = OP_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    checkOutput("resetBeatsStart", 64'(busy), 64'd0);
    rst = 1'b0; start = 1'b0;
    repeat (45) @(negedge clk);
    checkOutput("idleAfterAbort", 64'(busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = pickOperand();
      rb  = pickOperand();
      rh  = {$urandom, $urandom};
      applyStimulus(rop, ra, rb, rh, refModel(rop, ra, rb, rh),
                    ((rop == OP_DIV) || (rop == OP_DIVU)) && (rb == 32'd0), 1'b1);
    end

    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("scoreboardDrained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
